// File: rtl/memoredf_pkg.sv
// Packet field layout and FSM state encoding
// shared by the packet serializer and its users.
package memoredf_pkg;

   localparam int ADDR_W   = 40;
   localparam int ID_W     = 16;
   localparam int LEN_W    = 8;
   localparam int SIZE_W   = 3;
   localparam int BURST_W  = 2;
   localparam int LOCK_W   = 1;
   localparam int CACHE_W  = 4;
   localparam int PROT_W   = 3;
   localparam int QOS_W    = 4;
   localparam int REGION_W = 4;
   localparam int USER_W   = 16;

   localparam int ADDR_OFF   = 0;
   localparam int ID_OFF     = ADDR_OFF + ADDR_W;
   localparam int LEN_OFF    = ID_OFF + ID_W;
   localparam int SIZE_OFF   = LEN_OFF + LEN_W;
   localparam int BURST_OFF  = SIZE_OFF + SIZE_W;
   localparam int LOCK_OFF   = BURST_OFF + BURST_W;
   localparam int CACHE_OFF  = LOCK_OFF + LOCK_W;
   localparam int PROT_OFF   = CACHE_OFF + CACHE_W;
   localparam int QOS_OFF    = PROT_OFF + PROT_W;
   localparam int REGION_OFF = QOS_OFF + QOS_W;
   localparam int USER_OFF   = REGION_OFF + REGION_W;
   localparam int WR_OFF     = USER_OFF + USER_W;
   localparam int HDR_W      = WR_OFF + 1;

   localparam int DEF_BEATS  = 4;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_STRB_W = DEF_DATA_W / 8;
   localparam int STRB_OFF   = HDR_W;
   localparam int DATA_OFF   = STRB_OFF + DEF_BEATS * DEF_STRB_W;
   localparam int PKT_W      = DATA_OFF + DEF_BEATS * DEF_DATA_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_ACK
   } ser_state_e;

endpackage

// File: rtl/packet_serializer.sv
// Issues one captured packet as an AXI4 read or write
// (address phase, then W beats for writes), then acks.
module packet_serializer
   import memoredf_pkg::*;
#(
   parameter int DATA_SIZE  = PKT_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int ID_WIDTH   = ID_W,
   parameter int DATA_WIDTH = DEF_DATA_W,
   parameter int MAX_BEATS  = DEF_BEATS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_SIZE-1:0]    selector_to_serializer_packet,
   input  logic                    scheduler_to_serializer_activate_signal,
   output logic                    serializer_to_scheduler_consumed,

   output logic                    m_axi_arvalid,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic [3:0]              m_axi_arregion,
   output logic [15:0]             m_axi_aruser,
   input  logic                    m_axi_arready,

   output logic                    m_axi_awvalid,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic [3:0]              m_axi_awregion,
   output logic [15:0]             m_axi_awuser,
   input  logic                    m_axi_awready,

   output logic                    m_axi_wvalid,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   input  logic                    m_axi_wready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int D_OFF  = STRB_OFF + MAX_BEATS * STRB_W;
   localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_BEATS - 1);

   ser_state_e state_q, state_d;

   logic [DATA_SIZE-1:0] pkt_q, pkt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic             activate;
   logic             is_wr;
   logic             ax_ready;
   logic             last_beat;
   logic [LEN_W-1:0] len_raw;
   logic [LEN_W-1:0] len_eff;

   logic [DATA_WIDTH-1:0] beat_data [MAX_BEATS];
   logic [STRB_W-1:0]     beat_strb [MAX_BEATS];

   assign activate  = scheduler_to_serializer_activate_signal;
   assign is_wr     = pkt_q[WR_OFF];
   assign len_raw   = pkt_q[LEN_OFF +: LEN_W];
   assign len_eff   = (len_raw > LEN_CAP) ? LEN_CAP : len_raw;
   assign last_beat = (cnt_q == len_eff[CNT_W-1:0]);
   assign ax_ready  = is_wr ? m_axi_awready : m_axi_arready;

   always_comb begin
      for (int k = 0; k < MAX_BEATS; k++) begin
         beat_strb[k] = pkt_q[STRB_OFF + k*STRB_W +: STRB_W];
         beat_data[k] = pkt_q[D_OFF + k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (activate) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (ax_ready) state_d = is_wr ? S_WDATA : S_ACK;
         end
         S_WDATA: begin
            if (m_axi_wready && last_beat) state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pkt_q <= '0;
         cnt_q <= '0;
      end else begin
         pkt_q <= pkt_d;
         cnt_q <= cnt_d;
      end
   end

   // Packet input is only looked at while idle
   always_comb begin
      pkt_d = pkt_q;
      cnt_d = cnt_q;
      if (state_q == S_IDLE && activate) begin
         pkt_d = selector_to_serializer_packet;
      end
      if (state_q == S_ADDR) begin
         cnt_d = '0;
      end
      if (state_q == S_WDATA && m_axi_wready) begin
         cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      m_axi_arvalid = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      serializer_to_scheduler_consumed = 1'b0;
      unique case (state_q)
         S_ADDR: begin
            m_axi_arvalid = !is_wr;
            m_axi_awvalid = is_wr;
         end
         S_WDATA: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = last_beat;
         end
         S_ACK: begin
            serializer_to_scheduler_consumed = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign m_axi_arid     = pkt_q[ID_OFF +: ID_WIDTH];
   assign m_axi_araddr   = pkt_q[ADDR_OFF +: ADDR_WIDTH];
   assign m_axi_arlen    = len_eff;
   assign m_axi_arsize   = pkt_q[SIZE_OFF +: SIZE_W];
   assign m_axi_arburst  = pkt_q[BURST_OFF +: BURST_W];
   assign m_axi_arlock   = pkt_q[LOCK_OFF];
   assign m_axi_arcache  = pkt_q[CACHE_OFF +: CACHE_W];
   assign m_axi_arprot   = pkt_q[PROT_OFF +: PROT_W];
   assign m_axi_arqos    = pkt_q[QOS_OFF +: QOS_W];
   assign m_axi_arregion = pkt_q[REGION_OFF +: REGION_W];
   assign m_axi_aruser   = pkt_q[USER_OFF +: USER_W];

   assign m_axi_awid     = pkt_q[ID_OFF +: ID_WIDTH];
   assign m_axi_awaddr   = pkt_q[ADDR_OFF +: ADDR_WIDTH];
   assign m_axi_awlen    = len_eff;
   assign m_axi_awsize   = pkt_q[SIZE_OFF +: SIZE_W];
   assign m_axi_awburst  = pkt_q[BURST_OFF +: BURST_W];
   assign m_axi_awlock   = pkt_q[LOCK_OFF];
   assign m_axi_awcache  = pkt_q[CACHE_OFF +: CACHE_W];
   assign m_axi_awprot   = pkt_q[PROT_OFF +: PROT_W];
   assign m_axi_awqos    = pkt_q[QOS_OFF +: QOS_W];
   assign m_axi_awregion = pkt_q[REGION_OFF +: REGION_W];
   assign m_axi_awuser   = pkt_q[USER_OFF +: USER_W];

   assign m_axi_wdata = beat_data[cnt_q];
   assign m_axi_wstrb = beat_strb[cnt_q];

endmodule

// File: tb/tb_packet_serializer.sv
// Random and directed stimulus for packet_serializer,
// checked against a transaction-level model.
module tb_packet_serializer;

   localparam int DS = 678;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DS-1:0] pkt;
   logic          act;
   logic          consumed;

   logic          arvalid, arlock, arready = 1'b1;
   logic [15:0]   arid, aruser;
   logic [39:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize, arprot;
   logic [1:0]    arburst;
   logic [3:0]    arcache, arqos, arregion;

   logic          awvalid, awlock, awready = 1'b1;
   logic [15:0]   awid, awuser;
   logic [39:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize, awprot;
   logic [1:0]    awburst;
   logic [3:0]    awcache, awqos, awregion;

   logic          wvalid, wlast, wready = 1'b1;
   logic [127:0]  wdata;
   logic [15:0]   wstrb;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rmode = 0;
   int bp_start = 0;

   logic [127:0] ar_q[$];
   logic [127:0] aw_q[$];
   logic [127:0] wd_q[$];
   logic [15:0]  ws_q[$];
   logic         wl_q[$];
   int cons_n = 0;
   int cons_cyc = 0;
   int hold_err = 0;
   int excl_err = 0;
   int aw_stall_n = 0;

   logic [127:0] arv, awv, ar_pv, aw_pv, wd_pv;
   logic [15:0]  ws_pv;
   logic         wl_pv;
   logic         ar_st = 1'b0, aw_st = 1'b0, w_st = 1'b0;

   packet_serializer dut (
      .clock(clk),
      .reset(rst_n),
      .selector_to_serializer_packet(pkt),
      .scheduler_to_serializer_activate_signal(act),
      .serializer_to_scheduler_consumed(consumed),
      .m_axi_arvalid(arvalid),
      .m_axi_arid(arid),
      .m_axi_araddr(araddr),
      .m_axi_arlen(arlen),
      .m_axi_arsize(arsize),
      .m_axi_arburst(arburst),
      .m_axi_arlock(arlock),
      .m_axi_arcache(arcache),
      .m_axi_arprot(arprot),
      .m_axi_arqos(arqos),
      .m_axi_arregion(arregion),
      .m_axi_aruser(aruser),
      .m_axi_arready(arready),
      .m_axi_awvalid(awvalid),
      .m_axi_awid(awid),
      .m_axi_awaddr(awaddr),
      .m_axi_awlen(awlen),
      .m_axi_awsize(awsize),
      .m_axi_awburst(awburst),
      .m_axi_awlock(awlock),
      .m_axi_awcache(awcache),
      .m_axi_awprot(awprot),
      .m_axi_awqos(awqos),
      .m_axi_awregion(awregion),
      .m_axi_awuser(awuser),
      .m_axi_awready(awready),
      .m_axi_wvalid(wvalid),
      .m_axi_wdata(wdata),
      .m_axi_wstrb(wstrb),
      .m_axi_wlast(wlast),
      .m_axi_wready(wready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Ready patterns: 0 always high, 1 random, 2 scripted backpressure
   always @(posedge clk) begin
      #1;
      case (rmode)
         0: begin
            arready = 1'b1;
            awready = 1'b1;
            wready  = 1'b1;
         end
         1: begin
            arready = 1'($urandom);
            awready = 1'($urandom);
            wready  = 1'($urandom);
         end
         default: begin
            arready = 1'b1;
            awready = ((cyc - bp_start) >= 6);
            wready  = cyc[0];
         end
      endcase
   end

   // Bus monitor: handshakes complete at the next rising edge
   always @(negedge clk) begin
      arv = {27'd0, araddr, arid, arlen, arsize, arburst, arlock,
             arcache, arprot, arqos, arregion, aruser};
      awv = {27'd0, awaddr, awid, awlen, awsize, awburst, awlock,
             awcache, awprot, awqos, awregion, awuser};
      if (!rst_n) begin
         ar_st = 1'b0;
         aw_st = 1'b0;
         w_st  = 1'b0;
      end else begin
         if (ar_st && (!arvalid || arv !== ar_pv)) hold_err++;
         if (aw_st && (!awvalid || awv !== aw_pv)) hold_err++;
         if (w_st && (!wvalid || wdata !== wd_pv ||
                      wstrb !== ws_pv || wlast !== wl_pv)) hold_err++;
         if (awvalid && wvalid) excl_err++;
         ar_st = arvalid && !arready;
         aw_st = awvalid && !awready;
         w_st  = wvalid && !wready;
         ar_pv = arv;
         aw_pv = awv;
         wd_pv = wdata;
         ws_pv = wstrb;
         wl_pv = wlast;
         if (awvalid && !awready) aw_stall_n++;
         if (arvalid && arready) ar_q.push_back(arv);
         if (awvalid && awready) aw_q.push_back(awv);
         if (wvalid && wready) begin
            wd_q.push_back(wdata);
            ws_q.push_back(wstrb);
            wl_q.push_back(wlast);
         end
         if (consumed) begin
            cons_n++;
            cons_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DS-1:0] rand_pkt();
      logic [703:0] t;
      for (int i = 0; i < 22; i++) t[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) t[56 +: 8] = 8'($urandom);
      else t[56 +: 8] = 8'($urandom_range(0, 5));
      return t[DS-1:0];
   endfunction

   // Expected address-channel contents, len clamped to 4 beats
   function automatic logic [127:0] exp_ax(input logic [DS-1:0] p);
      logic [7:0] l;
      l = p[56 +: 8];
      if (l > 8'd3) l = 8'd3;
      return {27'd0, p[0 +: 40], p[40 +: 16], l, p[64 +: 3], p[67 +: 2],
              p[69], p[70 +: 4], p[74 +: 3], p[77 +: 4], p[81 +: 4],
              p[85 +: 16]};
   endfunction

   function automatic int exp_beats(input logic [DS-1:0] p);
      int l;
      l = int'(p[56 +: 8]);
      return (l > 3 ? 3 : l) + 1;
   endfunction

   task automatic wait_cons(input int cb);
      int n;
      n = 0;
      while (cons_n == cb && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("cons_timeout", 128'(n < 300), 1);
   endtask

   task automatic check_model(input logic [DS-1:0] p, input int arb,
                              input int ab, input int wb, input int cb);
      int beats;
      beats = p[101] ? exp_beats(p) : 0;
      chk("cons_count", cons_n - cb, 1);
      chk("hold_err", hold_err, 0);
      chk("aw_w_excl", excl_err, 0);
      chk("ar_count", ar_q.size() - arb, p[101] ? 0 : 1);
      chk("aw_count", aw_q.size() - ab, p[101] ? 1 : 0);
      chk("w_count", wd_q.size() - wb, beats);
      if (!p[101] && ar_q.size() > arb) chk("ar_fields", ar_q[arb], exp_ax(p));
      if (p[101] && aw_q.size() > ab) chk("aw_fields", aw_q[ab], exp_ax(p));
      for (int k = 0; k < beats && wb + k < wd_q.size(); k++) begin
         chk("w_data", wd_q[wb+k], p[166 + 128*k +: 128]);
         chk("w_strb", ws_q[wb+k], p[102 + 16*k +: 16]);
         chk("w_last", wl_q[wb+k], 128'(k == beats - 1));
      end
   endtask

   task automatic run_txn(input logic [DS-1:0] p, input bit timed);
      int arb, ab, wb, cb, start;
      arb = ar_q.size();
      ab  = aw_q.size();
      wb  = wd_q.size();
      cb  = cons_n;
      @(posedge clk);
      #1;
      bp_start = cyc;
      pkt = p;
      act = 1'b1;
      start = cyc;
      @(posedge clk);
      #1;
      act = 1'b0;
      pkt = rand_pkt();
      wait_cons(cb);
      if (timed) begin
         chk("turnaround", cons_cyc - start + 1,
             p[101] ? 3 + exp_beats(p) : 3);
      end
      repeat (2) @(negedge clk);
      #1;
      check_model(p, arb, ab, wb, cb);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DS-1:0] p, p2;
      logic [127:0] v;
      int arb, ab, wb, cb, n;

      rst_n = 1'b0;
      act = 1'b0;
      pkt = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valids", {arvalid, awvalid, wvalid, wlast, consumed}, 0);
      chk("rst_ar", {araddr, arid, arlen, aruser}, 0);
      chk("rst_aw", {awaddr, awid, awlen, awuser}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", wstrb, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Single read
      p = '0;
      p[0 +: 40] = 40'h00_1000_0040;
      p[40 +: 16] = 16'h0003;
      p[85 +: 16] = 16'h5a5a;
      arb = ar_q.size();
      run_txn(p, 1'b1);
      v = (ar_q.size() > arb) ? ar_q[arb] : '1;
      chk("r_addr", v[100:61], 40'h00_1000_0040);
      chk("r_id", v[60:45], 16'h0003);

      // Four-beat write with known data
      p = rand_pkt();
      p[101] = 1'b1;
      p[56 +: 8] = 8'd3;
      for (int k = 0; k < 4; k++) p[166 + 128*k +: 128] = 128'(10 + k);
      wb = wd_q.size();
      run_txn(p, 1'b1);
      for (int k = 0; k < 4 && wb + k < wd_q.size(); k++) begin
         chk("w4_data", wd_q[wb+k], 128'(10 + k));
      end

      // Backpressure on AW and W
      rmode = 2;
      p = rand_pkt();
      p[101] = 1'b1;
      p[56 +: 8] = 8'd3;
      n = aw_stall_n;
      run_txn(p, 1'b0);
      chk("bp_aw_stall", aw_stall_n - n, 5);
      rmode = 0;

      // Length clamping
      p = rand_pkt();
      p[101] = 1'b1;
      p[56 +: 8] = 8'd7;
      ab = aw_q.size();
      run_txn(p, 1'b1);
      v = (aw_q.size() > ab) ? aw_q[ab] : '1;
      chk("clamp_len", v[44:37], 3);

      // Activate held high through ACK
      p = rand_pkt();
      p[101] = 1'b0;
      p2 = rand_pkt();
      p2[101] = 1'b0;
      arb = ar_q.size();
      cb = cons_n;
      @(posedge clk);
      #1;
      pkt = p;
      act = 1'b1;
      @(posedge clk);
      #1;
      pkt = p2;
      wait_cons(cb);
      @(negedge clk);
      #1;
      chk("ack_no_capture", arvalid, 0);
      @(negedge clk);
      #1;
      chk("idle_recapture", arvalid, 1);
      @(posedge clk);
      #1;
      act = 1'b0;
      wait_cons(cb + 1);
      repeat (2) @(negedge clk);
      #1;
      chk("held_cons", cons_n - cb, 2);
      chk("held_ar_n", ar_q.size() - arb, 2);
      if (ar_q.size() > arb + 1) begin
         chk("held_ar0", ar_q[arb], exp_ax(p));
         chk("held_ar1", ar_q[arb+1], exp_ax(p2));
      end

      // Reset during W beat 1
      p = rand_pkt();
      p[101] = 1'b1;
      p[56 +: 8] = 8'd3;
      wb = wd_q.size();
      @(posedge clk);
      #1;
      pkt = p;
      act = 1'b1;
      @(posedge clk);
      #1;
      act = 1'b0;
      n = 0;
      while (!(wd_q.size() - wb == 2 && wvalid) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("beat1_timeout", 128'(n < 50), 1);
      cb = cons_n;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async", {arvalid, awvalid, wvalid, wlast, consumed}, 0);
      @(negedge clk);
      #1;
      chk("rst_mid_aw", {awaddr, awlen, awid}, 0);
      chk("rst_mid_wdata", wdata, 0);
      chk("rst_mid_wstrb", wstrb, 0);
      p = rand_pkt();
      p[101] = 1'b0;
      arb = ar_q.size();
      ab = aw_q.size();
      wb = wd_q.size();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      pkt = p;
      act = 1'b1;
      @(posedge clk);
      #1;
      act = 1'b0;
      @(negedge clk);
      #1;
      chk("first_edge_cap", arvalid, 1);
      wait_cons(cb);
      repeat (2) @(negedge clk);
      #1;
      check_model(p, arb, ab, wb, cb);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         rmode = ($urandom_range(0, 2) == 0) ? 1 : 0;
         p = rand_pkt();
         run_txn(p, rmode == 0);
      end
      rmode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
